// File: rtl/clock_display_pkg.sv
// Shared definitions for the clock display scanner.
//   NUM_DIGITS  : number of multiplexed digits in a frame
//   digit_idx_t : digit slot index (0 = sec ones .. 3 = min tens)
//   SEG_*       : 7-segment patterns {g,f,e,d,c,b,a}, active-high
//   CODE_*      : special codes understood by seg7_encode
package clock_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_DASH = 4'd10;

endpackage

// File: rtl/clock_display_scan_seg7_encode.sv
// seg7_encode: combinational digit code to 7-segment pattern.
//   code : 0..9 decimal digit, 10 dash, 11..15 blank
//   seg  : segments {g,f,e,d,c,b,a}, active-high
module seg7_encode
  import clock_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: multiplexed 4-digit MM:SS 7-segment scanner.
// A prescaler divides clk into digit slots of SCAN_DIV cycles; a 2-bit
// index walks the four digits. The time is snapshotted once per frame so
// a frame never mixes old and new digits. The first cycle of every slot
// is blanked to suppress ghosting.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   sec_in   : binary seconds 0..59 (60..63 shown as dashes)
//   min_in   : binary minutes 0..59 (60..63 shown as dashes)
//   sec_tick : one-cycle pulse per second (blink source)
//   seg_out  : segments {g,f,e,d,c,b,a}, active-high, registered
//   dp_out   : decimal point, active-high, registered
//   dig_sel  : one-hot digit enable, bit0 sec ones .. bit3 min tens
// Build option: define CLOCK_DISPLAY_DP_BLINK_EN to blink the decimal point
// of the minute-ones digit (colon-style separator) on every sec_tick.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic       sec_tick,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] dig_sel
);

  localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam digit_idx_t     IDX_LAST   = digit_idx_t'(NUM_DIGITS - 1);
  localparam digit_idx_t     IDX_DP     = digit_idx_t'(2);

  // Tens/ones split by restoring compare-subtract; valid for 0..59.
  function automatic logic [7:0] split_tens_ones(input logic [5:0] f);
    logic [5:0] r;
    logic [3:0] t;
    r = f;
    t = 4'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
    return {t, r[3:0]};
  endfunction

  logic [PW-1:0] presc_p0;
  digit_idx_t    idx_p0;
  logic [5:0]    snap_sec_p0;
  logic [5:0]    snap_min_p0;
  logic          presc_wrap;
  logic [7:0]    sec_split;
  logic [7:0]    min_split;
  logic          sec_bad;
  logic          min_bad;
  logic [3:0]    code;
  logic [6:0]    seg_nxt;
  logic          blank_slot;

  // Stage p0: prescaler, digit index and frame snapshot
  assign presc_wrap = (presc_p0 == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_p0    <= '0;
      idx_p0      <= '0;
      snap_sec_p0 <= '0;
      snap_min_p0 <= '0;
    end else begin
      presc_p0 <= presc_wrap ? '0 : presc_p0 + 1'b1;
      if (presc_wrap) begin
        idx_p0 <= idx_p0 + 1'b1;
        // Snapshot only on the frame boundary so every frame is coherent.
        if (idx_p0 == IDX_LAST) begin
          snap_sec_p0 <= sec_in;
          snap_min_p0 <= min_in;
        end
      end
    end
  end

  assign sec_split  = split_tens_ones(snap_sec_p0);
  assign min_split  = split_tens_ones(snap_min_p0);
  assign sec_bad    = (snap_sec_p0 >= 6'd60);
  assign min_bad    = (snap_min_p0 >= 6'd60);
  assign blank_slot = (presc_p0 == '0);

  always_comb begin
    code = CODE_DASH;
    case (idx_p0)
      2'd0:    code = sec_bad ? CODE_DASH : sec_split[3:0];
      2'd1:    code = sec_bad ? CODE_DASH : sec_split[7:4];
      2'd2:    code = min_bad ? CODE_DASH : min_split[3:0];
      default: code = min_bad ? CODE_DASH : min_split[7:4];
    endcase
  end

  seg7_encode u_enc (
    .code (code),
    .seg  (seg_nxt)
  );

  // Stage p1: registered outputs; digit enable and segments move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel <= '0;
      seg_out <= '0;
    end else if (blank_slot) begin
      dig_sel <= '0;
      seg_out <= '0;
    end else begin
      dig_sel <= 4'b0001 << idx_p0;
      seg_out <= seg_nxt;
    end
  end

`ifdef CLOCK_DISPLAY_DP_BLINK_EN
  logic blink_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_p0 <= 1'b0;
      dp_out   <= 1'b0;
    end else begin
      if (sec_tick) blink_p0 <= ~blink_p0;
      dp_out <= (!blank_slot && idx_p0 == IDX_DP) ? blink_p0 : 1'b0;
    end
  end
`else
  logic unused_sec_tick;
  logic unused_idx_dp;

  assign unused_sec_tick = sec_tick;
  assign unused_idx_dp   = ^IDX_DP;
  assign dp_out          = 1'b0;
`endif

endmodule

// File: tb/tb_clock_display_scan.sv
module tb_clock_display_scan;

  logic       clk;
  logic       rst_n;
  logic [5:0] sec_in;
  logic [5:0] min_in;
  logic       sec_tick;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] dig_sel;

  clock_display_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sec_in   (sec_in),
    .min_in   (min_in),
    .sec_tick (sec_tick),
    .seg_out  (seg_out),
    .dp_out   (dp_out),
    .dig_sel  (dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]       mn;
    logic [5:0]       sc;
    logic [3:0][6:0]  e;   // expected segments per slot 0..3
  } vec_t;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[9];
  int   total;
  int   bad;
  logic blink_exp;

  function automatic vec_t mk(input int mn, input int sc, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3);
    vec_t v;
    v.mn = 6'(mn);
    v.sc = 6'(sc);
    v.e  = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc, input exp_t got, input exp_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc%0d: got dig=%b seg=%h dp=%b want dig=%b seg=%h dp=%b",
               nm, cyc, got.dig, got.seg, got.dp, want.dig, want.seg, want.dp);
    end
  endtask

  // Runs one 16-cycle frame (SCAN_DIV=4). Called right after a frame
  // boundary; applies the inputs that the next frame will snapshot and
  // checks the frame currently being shown against cur.
  task automatic run_frame(input string nm, input logic [5:0] nmin, input logic [5:0] nsec,
                           input bit mid, input logic [5:0] msec, input bit tick,
                           input vec_t cur);
    exp_t w;
    exp_t g;
    min_in = nmin;
    sec_in = nsec;
    if (tick) begin
      sec_tick = 1'b1;
`ifdef CLOCK_DISPLAY_DP_BLINK_EN
      blink_exp = ~blink_exp;
`endif
    end
    for (int j = 0; j < 16; j++) begin
      if (j % 4 == 0) w = '{dig: 4'b0000, seg: 7'h00, dp: 1'b0};
      else begin
        w.dig = 4'b0001 << (j / 4);
        w.seg = cur.e[j / 4];
        w.dp  = (j / 4 == 2) ? blink_exp : 1'b0;
      end
      exp_q.push_back(w);
    end
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1;
      sec_tick = 1'b0;
      if (mid && j == 7) sec_in = msec;
      g = '{dig: dig_sel, seg: seg_out, dp: dp_out};
      chk(nm, j, g, exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t g;
    vec_t v00;
    vec_t nv;
    total = 0;
    bad = 0;
    blink_exp = 1'b0;

    tbl[0] = mk(47, 59, 7'h6F, 7'h6D, 7'h07, 7'h66);
    tbl[1] = mk(12, 34, 7'h66, 7'h4F, 7'h5B, 7'h06);
    tbl[2] = mk( 8,  5, 7'h6D, 7'h3F, 7'h7F, 7'h3F);
    tbl[3] = mk( 0, 62, 7'h40, 7'h40, 7'h3F, 7'h3F);
    tbl[4] = mk(19, 62, 7'h40, 7'h40, 7'h6F, 7'h06);
    tbl[5] = mk(63, 10, 7'h3F, 7'h06, 7'h40, 7'h40);
    tbl[6] = mk(26, 51, 7'h06, 7'h6D, 7'h7D, 7'h5B);
    tbl[7] = mk(30, 48, 7'h7F, 7'h66, 7'h3F, 7'h4F);
    tbl[8] = mk( 0,  0, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    v00 = tbl[8];

    // Reset: outputs held at zero while rst_n is low
    rst_n = 1'b0;
    sec_in = 6'd0;
    min_in = 6'd0;
    sec_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    g = '{dig: dig_sel, seg: seg_out, dp: dp_out};
    chk("reset_hold", 0, g, '{dig: 4'b0000, seg: 7'h00, dp: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // First frame shows 00:00 and begins with a blank cycle
    run_frame("frame0", tbl[0].mn, tbl[0].sc, 1'b0, 6'd0, 1'b0, v00);

    // Decode / range table
    for (int i = 0; i < 9; i++) begin
      if (i < 8) nv = tbl[i + 1];
      else nv = mk(0, 12, 7'h00, 7'h00, 7'h00, 7'h00);
      run_frame($sformatf("vec%0d", i), nv.mn, nv.sc, 1'b0, 6'd0, 1'b0, tbl[i]);
    end

    // Tearing: sec 12 -> 34 mid-frame, frame keeps 12, next shows 34
    run_frame("tear_a", 6'd0, 6'd12, 1'b1, 6'd34, 1'b0,
              mk(0, 12, 7'h5B, 7'h06, 7'h3F, 7'h3F));
    run_frame("tear_b", 6'd0, 6'd34, 1'b0, 6'd0, 1'b0,
              mk(0, 34, 7'h66, 7'h4F, 7'h3F, 7'h3F));

    // Blink: three sec_tick pulses
    for (int k = 0; k < 3; k++)
      run_frame($sformatf("blink%0d", k), 6'd0, 6'd34, 1'b0, 6'd0, 1'b1,
                mk(0, 34, 7'h66, 7'h4F, 7'h3F, 7'h3F));

    // Async reset mid-frame while digit 2 is driven
    min_in = 6'd47;
    sec_in = 6'd59;
    repeat (10) @(posedge clk);
    #1;
    g = '{dig: dig_sel, seg: seg_out, dp: dp_out};
    chk("abort_pre", 10, g, '{dig: 4'b0100, seg: 7'h3F, dp: blink_exp});
    #2;
    rst_n = 1'b0;
    #1;
    g = '{dig: dig_sel, seg: seg_out, dp: dp_out};
    chk("abort_async", 0, g, '{dig: 4'b0000, seg: 7'h00, dp: 1'b0});
    blink_exp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("restart", 6'd47, 6'd59, 1'b0, 6'd0, 1'b0, v00);
    run_frame("after_restart", 6'd47, 6'd59, 1'b0, 6'd0, 1'b0, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
